// File: rtl/branch_pc_unit.sv
// branch_pc_unit
//   Program-counter and branch-resolution stage. Combines the comparator
//   Zero flag with the decoded Branch/Jump controls, holds and advances the
//   32-bit PC, defers redirects that arrive during a hazard stall, and
//   emits a one-cycle Flush after every redirect to squash wrong-path
//   instructions in IF/ID.
//
//   Optional feature macro: BRANCH_STATS_EN
//     defined   -> STAT_W parameter and saturating BranchCount/TakenCount
//                  statistics ports are present.
//     undefined -> counters and ports are absent; all else is identical.

module branch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
`ifdef BRANCH_STATS_EN
  ,
  parameter int unsigned STAT_W   = 16
`endif
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Stall,
  input  logic              Branch,
  input  logic              Zero,
  input  logic [31:0]       BranchTarget,
  input  logic              Jump,
  input  logic [31:0]       JumpTarget,
  output logic [31:0]       PC,
  output logic [31:0]       PCPlus4,
  output logic              Flush,
`ifdef BRANCH_STATS_EN
  output logic [STAT_W-1:0] BranchCount,
  output logic [STAT_W-1:0] TakenCount,
`endif
  output logic              RedirectPending
);

  // RUN: normal fetch; PEND: redirect waiting for the stall to clear;
  // FLUSH: the instruction fetched in this cycle is on the wrong path.
  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_PEND  = 2'd1,
    S_FLUSH = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_q, pend_d;
  logic        redirect;
  logic [31:0] target;

  // Jump has priority over a taken branch; targets are always word aligned.
  assign redirect = Jump | (Branch & Zero);
  assign target   = (Jump ? JumpTarget : BranchTarget) & 32'hFFFF_FFFC;

  assign PC              = pc_q;
  assign PCPlus4         = pc_q + 32'd4;
  assign Flush           = (state_q == S_FLUSH);
  assign RedirectPending = (state_q == S_PEND);

  // Next-state, next-PC and pending-target selection.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path
    // leaves it unassigned, which would otherwise infer a latch.
    state_d = state_q;
    pc_d    = pc_q;
    pend_d  = pend_q;
    unique case (state_q)
      S_RUN: begin
        if (redirect) begin
          if (Stall) begin
            pend_d  = target;
            state_d = S_PEND;
          end else begin
            pc_d    = target;
            state_d = S_FLUSH;
          end
        end else if (!Stall) begin
          pc_d = PCPlus4;
        end
      end
      S_PEND: begin
        // New Branch/Jump requests are ignored while a redirect is queued.
        if (!Stall) begin
          pc_d    = pend_q;
          state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        // The instruction in flight is wrong-path, so its controls are ignored.
        if (!Stall) pc_d = PCPlus4;
        state_d = S_RUN;
      end
      default: state_d = S_RUN;
    endcase
  end

  // State, PC and pending-target registers.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= S_RUN;
      pc_q    <= RESET_PC;
      pend_q  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
    end
  end

`ifdef BRANCH_STATS_EN
  logic              branch_acc;
  logic              branch_taken;
  logic [STAT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [STAT_W-1:0] taken_cnt_q, taken_cnt_d;

  // A branch is accepted in RUN when it resolves now, or when it is taken
  // and gets queued behind a stall; a stalled not-taken branch is re-presented.
  assign branch_acc   = (state_q == S_RUN) & Branch & (~Stall | Zero);
  assign branch_taken = branch_acc & Zero;

  // Saturating increments of the statistics counters.
  always_comb begin
    branch_cnt_d = branch_cnt_q;
    taken_cnt_d  = taken_cnt_q;
    if (branch_acc && (branch_cnt_q != '1))  branch_cnt_d = branch_cnt_q + 1'b1;
    if (branch_taken && (taken_cnt_q != '1)) taken_cnt_d  = taken_cnt_q + 1'b1;
  end

  // Statistics counter registers.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      branch_cnt_q <= '0;
      taken_cnt_q  <= '0;
    end else begin
      branch_cnt_q <= branch_cnt_d;
      taken_cnt_q  <= taken_cnt_d;
    end
  end

  assign BranchCount = branch_cnt_q;
  assign TakenCount  = taken_cnt_q;
`endif

endmodule

// File: tb/tb_branch_pc_unit.sv
// Self-checking bench for branch_pc_unit: directed steps from the test plan
// followed by randomized cycles, all compared against a behavioural model
// that tracks the fetch address, a queued-redirect flag and a wrong-path flag.

module tb_branch_pc_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef BRANCH_STATS_EN
  localparam int unsigned TB_STAT_W = 2;
`endif

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Stall, Branch, Zero, Jump;
  logic [31:0] BranchTarget, JumpTarget;
  logic [31:0] PC, PCPlus4;
  logic        Flush, RedirectPending;
`ifdef BRANCH_STATS_EN
  logic [TB_STAT_W-1:0] BranchCount, TakenCount;
  int unsigned m_bcnt, m_tcnt;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [31:0] m_pc;
  bit          m_pend;
  logic [31:0] m_tgt;
  bit          m_flush;

  branch_pc_unit #(
    .RESET_PC(RESET_PC)
`ifdef BRANCH_STATS_EN
    , .STAT_W(TB_STAT_W)
`endif
  ) dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .Stall          (Stall),
    .Branch         (Branch),
    .Zero           (Zero),
    .BranchTarget   (BranchTarget),
    .Jump           (Jump),
    .JumpTarget     (JumpTarget),
    .PC             (PC),
    .PCPlus4        (PCPlus4),
    .Flush          (Flush),
`ifdef BRANCH_STATS_EN
    .BranchCount    (BranchCount),
    .TakenCount     (TakenCount),
`endif
    .RedirectPending(RedirectPending)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc    = RESET_PC;
    m_pend  = 1'b0;
    m_tgt   = 32'h0;
    m_flush = 1'b0;
`ifdef BRANCH_STATS_EN
    m_bcnt = 0;
    m_tcnt = 0;
`endif
  endtask

  // Compare every DUT output with the model.
  task automatic check_all(input string tag);
    check({tag, ".pc"},     PC,                     m_pc);
    check({tag, ".pc4"},    PCPlus4,                m_pc + 32'd4);
    check({tag, ".flush"},  {31'd0, Flush},         {31'd0, m_flush});
    check({tag, ".pend"},   {31'd0, RedirectPending}, {31'd0, m_pend});
`ifdef BRANCH_STATS_EN
    check({tag, ".bcnt"},   32'(BranchCount),       m_bcnt);
    check({tag, ".tcnt"},   32'(TakenCount),        m_tcnt);
`endif
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_edge();
    bit          red;
    logic [31:0] tgt;
    if (m_flush) begin
      if (!Stall) m_pc = m_pc + 32'd4;
      m_flush = 1'b0;
    end else if (m_pend) begin
      if (!Stall) begin
        m_pc    = m_tgt;
        m_pend  = 1'b0;
        m_flush = 1'b1;
      end
    end else begin
`ifdef BRANCH_STATS_EN
      if (Branch && (!Stall || Zero)) begin
        if (m_bcnt < 3) m_bcnt++;
        if (Zero && m_tcnt < 3) m_tcnt++;
      end
`endif
      red = Jump || (Branch && Zero);
      tgt = Jump ? JumpTarget : BranchTarget;
      tgt[1:0] = 2'b00;
      if (red && Stall) begin
        m_pend = 1'b1;
        m_tgt  = tgt;
      end else if (red) begin
        m_pc    = tgt;
        m_flush = 1'b1;
      end else if (!Stall) begin
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  // One clock cycle with the given inputs, then check 1 time unit after the edge.
  task automatic cyc(input string tag, input bit st, input bit br, input bit z,
                     input logic [31:0] bt, input bit j, input logic [31:0] jt);
    Stall = st; Branch = br; Zero = z; BranchTarget = bt; Jump = j; JumpTarget = jt;
    @(posedge Clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic idle(input string tag);
    cyc(tag, 0, 0, 0, 32'h0, 0, 32'h0);
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset = 1'b1;
    model_reset();
    #1;
    check_all("reset");
    @(negedge Clk);
    Reset = 1'b0;
    #1;
    check_all("reset_rel");
  endtask

  initial begin
    Reset = 1'b1;
    Stall = 0; Branch = 0; Zero = 0; Jump = 0;
    BranchTarget = 32'h0; JumpTarget = 32'h0;
    model_reset();
    repeat (2) @(posedge Clk);
    do_reset();
    check("reset_pc_const", PC, 32'h0);

    // Sequential fetch.
    for (int i = 1; i <= 4; i++) begin
      idle("seq");
      check("seq_const", PC, 32'(i * 4));
    end

    // Taken branch at 0x10.
    cyc("br_taken", 0, 1, 1, 32'h40, 0, 32'h0);
    check("br_taken_pc", PC, 32'h40);
    check("br_taken_flush", {31'd0, Flush}, 32'd1);
    idle("br_after");
    check("br_after_pc", PC, 32'h44);
    // Not-taken branch.
    cyc("br_nt", 0, 1, 0, 32'h80, 0, 32'h0);
    check("br_nt_pc", PC, 32'h48);

    // Stalled jump to 0x103; a branch during PEND is ignored.
    cyc("jstall1", 1, 0, 0, 32'h0, 1, 32'h103);
    check("jstall_pend", {31'd0, RedirectPending}, 32'd1);
    cyc("jstall2", 1, 1, 1, 32'h500, 0, 32'h0);
    cyc("jstall3", 1, 0, 0, 32'h0, 0, 32'h0);
    check("jstall_hold", PC, 32'h48);
    idle("jrelease");
    check("jrelease_pc", PC, 32'h100);
    // Taken branch during FLUSH is ignored.
    cyc("flush_ign", 0, 1, 1, 32'h600, 0, 32'h0);
    check("flush_ign_pc", PC, 32'h104);

    // Jump beats a simultaneous taken branch.
    cyc("prio", 0, 1, 1, 32'h300, 1, 32'h200);
    check("prio_pc", PC, 32'h200);
    idle("prio_after");

    // Reset asserted asynchronously while in PEND.
    cyc("pend_for_rst", 1, 0, 0, 32'h0, 1, 32'h7000);
    #2;
    Reset = 1'b1;
    model_reset();
    #1;
    check_all("rst_mid_pend");
    check("rst_mid_pend_pc", PC, RESET_PC);
    @(negedge Clk);
    Reset = 1'b0;
    idle("post_rst1");
    idle("post_rst2");
    check("post_rst_pc", PC, RESET_PC + 32'd8);

    // PC wrap: jump to 0xFFFF_FFF8, then two sequential fetches.
    cyc("wrap_j", 0, 0, 0, 32'h0, 1, 32'hFFFF_FFF8);
    idle("wrap1");
    check("wrap_fc", PC, 32'hFFFF_FFFC);
    idle("wrap2");
    check("wrap_zero", PC, 32'h0);

`ifdef BRANCH_STATS_EN
    // Five taken branches saturate both 2-bit counters.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cyc("stat_br", 0, 1, 1, 32'(32'h1000 + i * 16), 0, 32'h0);
      idle("stat_fl");
    end
    check("stat_bsat", 32'(BranchCount), 32'd3);
    check("stat_tsat", 32'(TakenCount), 32'd3);
    do_reset();
`endif

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      cyc("rand",
          ($urandom_range(0, 2) == 0),
          ($urandom_range(0, 2) == 0),
          $urandom_range(0, 1) == 1,
          $urandom,
          ($urandom_range(0, 5) == 0),
          $urandom);
      if ($urandom_range(0, 99) == 0) do_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_pc_unit.md
# branch_pc_unit

Program-counter and branch-resolution stage that consumes the `Zero` flag produced by the branch comparator ALU. Combines `Zero` with the decoded branch/jump controls, holds and advances the 32-bit PC, and defers redirects that arrive during a hazard stall. Emits a one-cycle `Flush` to squash wrong-path instructions in IF/ID. Sits between the execute-stage comparator and the instruction-fetch PC mux.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `STAT_W`, 16, width of the statistics counters (only with `BRANCH_STATS_EN`).

- `Clk`  in  1  rising-edge clock.
- `Reset`  in  1  asynchronous, active-high reset.
- `Stall`  in  1  hazard stall; PC holds while high.
- `Branch`  in  1  a conditional branch is being evaluated this cycle.
- `Zero`  in  1  comparator condition flag; 1 = branch condition met.
- `BranchTarget`  in  32  PC+4+(imm<<2), computed upstream.
- `Jump`  in  1  j/jal/jr this cycle (unconditional).
- `JumpTarget`  in  32  jump destination.
- `PC`  out  32  registered current fetch address.
- `PCPlus4`  out  32  combinational `PC + 4`, modulo 2^32.
- `Flush`  out  1  registered one-cycle squash pulse.
- `RedirectPending`  out  1  high in state PEND.
- `BranchCount`  out  STAT_W  branches accepted (`BRANCH_STATS_EN` only).
- `TakenCount`  out  STAT_W  branches taken (`BRANCH_STATS_EN` only).

## Operation
- `redirect = Jump | (Branch & Zero)`. Target = `JumpTarget` if `Jump`, else `BranchTarget`. Bits [1:0] of any loaded target are forced to 0.
- States: RUN, PEND, FLUSH. Reset state RUN.
- RUN:
  - `redirect & !Stall` -> PC <= target, go FLUSH.
  - `redirect & Stall` -> target latched into an internal pending register, PC holds, go PEND.
  - `!redirect & !Stall` -> PC <= PC+4.
  - `!redirect & Stall` -> PC holds.
- PEND: `Branch`/`Jump` ignored.
  - `Stall` -> hold.
  - `!Stall` -> PC <= pending target, go FLUSH.
- FLUSH: `Flush`=1. `Branch`/`Jump` ignored (wrong-path instruction).
  - `!Stall` -> PC <= PC+4.
  - `Stall` -> PC holds.
  - Always returns to RUN next cycle.
- Simultaneous `Jump` and `Branch&Zero`: jump wins.
- PC+4 wraps 32'hFFFF_FFFC -> 32'h0000_0000.

## Timing
- Reset (async, any cycle, including mid-PEND): `PC`=`RESET_PC`, `Flush`=0, `RedirectPending`=0, pending register=0, counters=0, state RUN.
- Redirect latency: target visible on `PC` one cycle after the accepting edge; `Flush` high for exactly that cycle.
- Stalled redirect: `PC` updates one edge after `Stall` falls.
- `Flush` is never high on two consecutive cycles.
- `PCPlus4` has zero latency from `PC`.

## Configuration
- `BRANCH_STATS_EN` defined: `BranchCount` and `TakenCount` ports are present.
  - `BranchCount` +1 when, in RUN, a branch is accepted: `Branch & !Stall`, or `Branch & Zero` captured into PEND.
  - `TakenCount` +1 when that accepted branch has `Zero`=1.
  - Both saturate at all-ones.
  - Jumps are not counted.
- `BRANCH_STATS_EN` undefined: counters and ports are absent; all other behaviour is identical.

## Test plan
- Sequential fetch: Reset pulse, then 4 idle cycles -> `PC` = 0,4,8,12,16; `Flush` stays 0.
- Taken branch: at PC=0x10 drive `Branch`=1, `Zero`=1, `BranchTarget`=0x40 -> next cycle `PC`=0x40 and `Flush`=1; following cycle `PC`=0x44 and `Flush`=0. Not-taken case (`Zero`=0) -> `PC`=0x14, no `Flush`.
- Stalled redirect: `Jump`=1, `JumpTarget`=0x103, `Stall`=1 for 3 cycles -> `PC` holds, `RedirectPending`=1. A branch presented during PEND is ignored. `Stall` falls -> `PC`=0x100, `Flush`=1.
- Priority and ignore: `Jump`=1 (0x200) together with `Branch`=1, `Zero`=1 (0x300) -> `PC`=0x200. A taken branch presented during FLUSH -> no redirect.
- Reset mid-PEND: assert `Reset` asynchronously while in PEND -> immediate `PC`=`RESET_PC`, `RedirectPending`=0. After release, PC counts up from `RESET_PC`.
- Wrap and stats: at PC=0xFFFF_FFFC idle -> `PC`=0. With `BRANCH_STATS_EN`, `STAT_W`=2, 5 taken branches -> both counters saturate at 3.
